// File: rtl/csi2_csr_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// csi2_csr_pkg : register indices of the CSI2 control/status block
// Rev 1.0
// ------------------------------------------------------------------
package csi2_csr_pkg;

  localparam int unsigned PHY_ENABLE_CR      = 0;
  localparam int unsigned SCCB_SLAVE_ADDR_CR = 1;
  localparam int unsigned LANE_0_DELAY_CR    = 2;
  localparam int unsigned LANE_1_DELAY_CR    = 3;
  localparam int unsigned DELAY_ACT_CR       = 4;
  localparam int unsigned CLEAR_STAT_CR      = 5;
  localparam int unsigned HEADER_ERR_CNT_SR  = 6;
  localparam int unsigned CRC_ERR_CNT_SR     = 7;

endpackage
`default_nettype wire

// File: rtl/csi2_delay_calib_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// csi2_delay_calib_pkg : FSM states and CSR addressing helper
// Rev 1.0
// ------------------------------------------------------------------
package csi2_delay_calib_pkg;

  localparam int unsigned CSR_WORD_BYTES = 4;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'd0,
    ST_W_L0     = 5'd1,
    ST_W_L1     = 5'd2,
    ST_ACT1     = 5'd3,
    ST_ACT0     = 5'd4,
    ST_SETTLE   = 5'd5,
    ST_CLR1     = 5'd6,
    ST_CLR0     = 5'd7,
    ST_DWELL    = 5'd8,
    ST_RD_HDR   = 5'd9,
    ST_RD_CRC   = 5'd10,
    ST_EVAL     = 5'd11,
    ST_NEXT     = 5'd12,
    ST_FIN_L0   = 5'd13,
    ST_FIN_L1   = 5'd14,
    ST_FIN_ACT1 = 5'd15,
    ST_FIN_ACT0 = 5'd16,
    ST_DONE     = 5'd17
  } calib_state_e;

  function automatic int unsigned csr_byte_addr(input int unsigned idx);
    return idx * CSR_WORD_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi2_delay_calib_if.sv
`default_nettype none
// ------------------------------------------------------------------
// axi4_lite_if : AXI4-Lite bundle with master/slave views
// Rev 1.0
// ------------------------------------------------------------------
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/csi2_delay_calib_axil_mst.sv
`default_nettype none
// ------------------------------------------------------------------
// csi2_axil_mst : single-outstanding AXI4-Lite master engine
// Rev 1.0
// ------------------------------------------------------------------
module csi2_axil_mst #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_req_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  axi4_lite_if.master           axi
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic                  busy_q,    busy_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;
  logic                  bready_q,  bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic unused_resp;

  assign w_aw_hs = awvalid_q & axi.awready;
  assign w_w_hs  = wvalid_q  & axi.wready;
  assign w_b_hs  = bready_q  & axi.bvalid;
  assign w_ar_hs = arvalid_q & axi.arready;
  assign w_r_hs  = rready_q  & axi.rvalid;

  // Responses are not checked; the sweep outcome reveals a broken CSR path.
  assign unused_resp = ^{axi.bresp, axi.rresp};

  always_comb begin
    busy_d    = busy_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (!busy_q) begin
      if (wr_req_i) begin
        busy_d    = 1'b1;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        addr_d    = addr_i;
        wdata_d   = wdata_i;
      end else if (rd_req_i) begin
        busy_d    = 1'b1;
        arvalid_d = 1'b1;
        addr_d    = addr_i;
      end
    end else begin
      if (w_aw_hs) begin
        awvalid_d = 1'b0;
        aw_done_d = 1'b1;
      end
      if (w_w_hs) begin
        wvalid_d = 1'b0;
        w_done_d = 1'b1;
      end
      // Address and data may complete in either order or together.
      if (w_b_hs) begin
        bready_d  = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        busy_d    = 1'b0;
      end else if ((aw_done_q | w_aw_hs) & (w_done_q | w_w_hs)) begin
        bready_d = 1'b1;
      end
      if (w_ar_hs) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      if (w_r_hs) begin
        rready_d = 1'b0;
        busy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign axi.awaddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = {STRB_W{1'b1}};
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Ack coincides with the final handshake, so rdata is valid alongside it.
  assign ack_o   = w_b_hs | w_r_hs;
  assign rdata_o = axi.rdata;

endmodule
`default_nettype wire

// File: rtl/csi2_delay_calib.sv
`default_nettype none
// ------------------------------------------------------------------
// csi2_delay_calib : sweeps lane IDELAY taps, programs window centre
// Rev 1.0
// ------------------------------------------------------------------
module csi2_delay_calib #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int TAP_CNT       = 32,
  parameter int SETTLE_CYCLES = 64,
  parameter int DWELL_CYCLES  = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [4:0] best_tap_o,
  output logic [5:0] win_len_o,
  axi4_lite_if.master csr_if
);

  import csi2_csr_pkg::*;
  import csi2_delay_calib_pkg::*;

  localparam int WAIT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] DWELL_LAST  = WAIT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);
  localparam logic [4:0] TAP_LAST = 5'(TAP_CNT - 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_L0  = ADDR_WIDTH'(csr_byte_addr(LANE_0_DELAY_CR));
  localparam logic [ADDR_WIDTH-1:0] ADDR_L1  = ADDR_WIDTH'(csr_byte_addr(LANE_1_DELAY_CR));
  localparam logic [ADDR_WIDTH-1:0] ADDR_ACT = ADDR_WIDTH'(csr_byte_addr(DELAY_ACT_CR));
  localparam logic [ADDR_WIDTH-1:0] ADDR_CLR = ADDR_WIDTH'(csr_byte_addr(CLEAR_STAT_CR));
  localparam logic [ADDR_WIDTH-1:0] ADDR_HDR = ADDR_WIDTH'(csr_byte_addr(HEADER_ERR_CNT_SR));
  localparam logic [ADDR_WIDTH-1:0] ADDR_CRC = ADDR_WIDTH'(csr_byte_addr(CRC_ERR_CNT_SR));

  calib_state_e state_q, state_d;

  logic [4:0]        tap_q,        tap_d;
  logic [5:0]        run_q,        run_d;
  logic [5:0]        best_len_q,   best_len_d;
  logic [4:0]        best_start_q, best_start_d;
  logic              hdr_bad_q,    hdr_bad_d;
  logic              crc_bad_q,    crc_bad_d;
  logic [WAIT_W-1:0] wait_q,       wait_d;
  logic              fail_q,       fail_d;
  logic [4:0]        best_tap_q,   best_tap_d;
  logic [5:0]        win_len_q,    win_len_d;

  logic                  w_wr_req;
  logic                  w_rd_req;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_ack;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [5:0]            w_run_inc;
  logic [4:0]            w_final_tap;

  assign w_run_inc   = run_q + 6'd1;
  // Centre of the window, rounding toward its start for even lengths.
  assign w_final_tap = (best_len_q == 6'd0) ? 5'd0
                     : best_start_q + 5'((best_len_q - 6'd1) >> 1);

  csi2_axil_mst #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mst (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_req_i (w_wr_req),
    .rd_req_i (w_rd_req),
    .addr_i   (w_addr),
    .wdata_i  (w_wdata),
    .ack_o    (w_ack),
    .rdata_o  (w_rdata),
    .axi      (csr_if)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      run_q        <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      hdr_bad_q    <= 1'b0;
      crc_bad_q    <= 1'b0;
      wait_q       <= '0;
      fail_q       <= 1'b0;
      best_tap_q   <= '0;
      win_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      run_q        <= run_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      hdr_bad_q    <= hdr_bad_d;
      crc_bad_q    <= crc_bad_d;
      wait_q       <= wait_d;
      fail_q       <= fail_d;
      best_tap_q   <= best_tap_d;
      win_len_q    <= win_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    run_d        = run_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    hdr_bad_d    = hdr_bad_q;
    crc_bad_d    = crc_bad_q;
    wait_d       = wait_q;
    fail_d       = fail_q;
    best_tap_d   = best_tap_q;
    win_len_d    = win_len_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        tap_d        = '0;
        run_d        = '0;
        best_len_d   = '0;
        best_start_d = '0;
        hdr_bad_d    = 1'b0;
        crc_bad_d    = 1'b0;
        wait_d       = '0;
        fail_d       = 1'b0;
        state_d      = ST_W_L0;
      end
      ST_W_L0: if (w_ack) state_d = ST_W_L1;
      ST_W_L1: if (w_ack) state_d = ST_ACT1;
      ST_ACT1: if (w_ack) state_d = ST_ACT0;
      ST_ACT0: if (w_ack) begin
        wait_d  = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (wait_q == SETTLE_LAST) state_d = ST_CLR1;
        else                       wait_d  = wait_q + 1'b1;
      end
      ST_CLR1: if (w_ack) state_d = ST_CLR0;
      ST_CLR0: if (w_ack) begin
        wait_d  = '0;
        state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (wait_q == DWELL_LAST) state_d = ST_RD_HDR;
        else                      wait_d  = wait_q + 1'b1;
      end
      ST_RD_HDR: if (w_ack) begin
        hdr_bad_d = |w_rdata;
        state_d   = ST_RD_CRC;
      end
      ST_RD_CRC: if (w_ack) begin
        crc_bad_d = |w_rdata;
        state_d   = ST_EVAL;
      end
      ST_EVAL: begin
        // Strict compare keeps the earliest window on a length tie.
        if (!hdr_bad_q && !crc_bad_q) begin
          run_d = w_run_inc;
          if (w_run_inc > best_len_q) begin
            best_len_d   = w_run_inc;
            best_start_d = tap_q - run_q[4:0];
          end
        end else begin
          run_d = '0;
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (tap_q == TAP_LAST) begin
          state_d = ST_FIN_L0;
        end else begin
          tap_d   = tap_q + 5'd1;
          state_d = ST_W_L0;
        end
      end
      ST_FIN_L0:   if (w_ack) state_d = ST_FIN_L1;
      ST_FIN_L1:   if (w_ack) state_d = ST_FIN_ACT1;
      ST_FIN_ACT1: if (w_ack) state_d = ST_FIN_ACT0;
      ST_FIN_ACT0: if (w_ack) begin
        best_tap_d = w_final_tap;
        win_len_d  = best_len_q;
        fail_d     = (best_len_q == 6'd0);
        state_d    = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    w_wr_req = 1'b0;
    w_rd_req = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    case (state_q)
      ST_W_L0:     begin w_wr_req = 1'b1; w_addr = ADDR_L0;  w_wdata = DATA_WIDTH'(tap_q); end
      ST_W_L1:     begin w_wr_req = 1'b1; w_addr = ADDR_L1;  w_wdata = DATA_WIDTH'(tap_q); end
      ST_ACT1:     begin w_wr_req = 1'b1; w_addr = ADDR_ACT; w_wdata = DATA_WIDTH'(1); end
      ST_ACT0:     begin w_wr_req = 1'b1; w_addr = ADDR_ACT; end
      ST_CLR1:     begin w_wr_req = 1'b1; w_addr = ADDR_CLR; w_wdata = DATA_WIDTH'(1); end
      ST_CLR0:     begin w_wr_req = 1'b1; w_addr = ADDR_CLR; end
      ST_RD_HDR:   begin w_rd_req = 1'b1; w_addr = ADDR_HDR; end
      ST_RD_CRC:   begin w_rd_req = 1'b1; w_addr = ADDR_CRC; end
      ST_FIN_L0:   begin w_wr_req = 1'b1; w_addr = ADDR_L0;  w_wdata = DATA_WIDTH'(w_final_tap); end
      ST_FIN_L1:   begin w_wr_req = 1'b1; w_addr = ADDR_L1;  w_wdata = DATA_WIDTH'(w_final_tap); end
      ST_FIN_ACT1: begin w_wr_req = 1'b1; w_addr = ADDR_ACT; w_wdata = DATA_WIDTH'(1); end
      ST_FIN_ACT0: begin w_wr_req = 1'b1; w_addr = ADDR_ACT; end
      default:     begin w_wr_req = 1'b0; end
    endcase
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign fail_o     = fail_q;
  assign best_tap_o = best_tap_q;
  assign win_len_o  = win_len_q;

endmodule
`default_nettype wire
